branch_hazard_unit: RTL and testbench

Stall generator for the ID-stage branch datapath. It detects when a branch or load-use consumer in IF/ID cannot yet obtain its operands through forwarding. It freezes PC and IF/ID and injects ID/EX bubbles for exactly the required number of cycles, and it flushes IF/ID on a taken branch. It sits beside the branch forwarding unit and guarantees that unit's precondition: one stall after an ALU producer, two after a load producer. It also keeps a stall-cycle performance counter.

---
 rtl/hazard_pkg.sv | 15 +
 rtl/reg_match.sv | 13 +
 rtl/branch_hazard_unit.sv | 110 +++++++++++
 tb/tb_branch_hazard_unit.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID-stage branch hazard logic.
package hazard_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned BR_W  = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    LOAD_WAIT = 2'b01
  } state_e;

  localparam logic [BR_W-1:0]  BR_NONE  = 2'b00;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/reg_match.sv
// Producer-destination vs. consumer-source compare; register 0 never matches.
module reg_match
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0] dest,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  output logic             hit_c
);

  assign hit_c = (dest != REG_ZERO) && ((dest == rs) || (dest == rt));

endmodule

// File: rtl/branch_hazard_unit.sv
// Stall/flush generator for the ID-stage branch datapath with a saturating
// stall-cycle counter.
module branch_hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BR_W-1:0]  Branch,
  input  logic             BranchTaken,
  input  logic [REG_W-1:0] IF_ID_RegisterRs,
  input  logic [REG_W-1:0] IF_ID_RegisterRt,
  input  logic             ID_EX_RegWrite,
  input  logic             ID_EX_MemRead,
  input  logic [REG_W-1:0] ID_EX_RegisterRd,
  input  logic             EX_MEM_MemRead,
  input  logic [REG_W-1:0] EX_MEM_RegisterRd,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             ID_EX_Bubble,
  output logic             IF_Flush,
  output logic [CNT_W-1:0] StallCycles
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ex_hit, mem_hit;
  logic             is_branch;
  logic             stall;

  reg_match u_ex_match (
    .dest  (ID_EX_RegisterRd),
    .rs    (IF_ID_RegisterRs),
    .rt    (IF_ID_RegisterRt),
    .hit_c (ex_hit)
  );

  reg_match u_mem_match (
    .dest  (EX_MEM_RegisterRd),
    .rs    (IF_ID_RegisterRs),
    .rt    (IF_ID_RegisterRt),
    .hit_c (mem_hit)
  );

  assign is_branch = (Branch != BR_NONE);

  // Priority-ordered hazard detection; a load feeding a branch needs a second cycle.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_branch && ID_EX_MemRead && ex_hit) begin
          stall   = 1'b1;
          state_d = LOAD_WAIT;
        end else if (is_branch && ID_EX_RegWrite && ex_hit) begin
          stall = 1'b1;
        end else if (is_branch && EX_MEM_MemRead && mem_hit) begin
          stall = 1'b1;
        end else if (!is_branch && ID_EX_MemRead && ex_hit) begin
          stall = 1'b1;
        end
      end
      LOAD_WAIT: begin
        stall   = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Pipeline held frozen with a bubble while reset is asserted.
  always_comb begin
    PCWrite      = 1'b0;
    IF_ID_Write  = 1'b0;
    ID_EX_Bubble = 1'b1;
    IF_Flush     = 1'b0;
    if (rst_n) begin
      PCWrite      = ~stall;
      IF_ID_Write  = ~stall;
      ID_EX_Bubble = stall;
      IF_Flush     = BranchTaken & ~stall;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign StallCycles = cnt_q;

endmodule

// File: tb/tb_branch_hazard_unit.sv
// Scoreboard bench for branch_hazard_unit: directed vectors, monitor checks on the falling edge.
module tb_branch_hazard_unit;

  logic        clk;
  logic        rst_n;
  logic [1:0]  Branch;
  logic        BranchTaken;
  logic [4:0]  Rs, Rt;
  logic        ex_rw, ex_mr;
  logic [4:0]  ex_rd;
  logic        mem_mr;
  logic [4:0]  mem_rd;

  logic        pcw, ifidw, bub, flush;
  logic [31:0] cnt32;
  logic        pcw4, ifidw4, bub4, flush4;
  logic [3:0]  cnt4;

  typedef struct {
    logic [3:0]  ctrl;
    int unsigned cnt;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  branch_hazard_unit #(.CNT_W(32)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .Branch            (Branch),
    .BranchTaken       (BranchTaken),
    .IF_ID_RegisterRs  (Rs),
    .IF_ID_RegisterRt  (Rt),
    .ID_EX_RegWrite    (ex_rw),
    .ID_EX_MemRead     (ex_mr),
    .ID_EX_RegisterRd  (ex_rd),
    .EX_MEM_MemRead    (mem_mr),
    .EX_MEM_RegisterRd (mem_rd),
    .PCWrite           (pcw),
    .IF_ID_Write       (ifidw),
    .ID_EX_Bubble      (bub),
    .IF_Flush          (flush),
    .StallCycles       (cnt32)
  );

  branch_hazard_unit #(.CNT_W(4)) dut4 (
    .clk               (clk),
    .rst_n             (rst_n),
    .Branch            (Branch),
    .BranchTaken       (BranchTaken),
    .IF_ID_RegisterRs  (Rs),
    .IF_ID_RegisterRt  (Rt),
    .ID_EX_RegWrite    (ex_rw),
    .ID_EX_MemRead     (ex_mr),
    .ID_EX_RegisterRd  (ex_rd),
    .EX_MEM_MemRead    (mem_mr),
    .EX_MEM_RegisterRd (mem_rd),
    .PCWrite           (pcw4),
    .IF_ID_Write       (ifidw4),
    .ID_EX_Bubble      (bub4),
    .IF_Flush          (flush4),
    .StallCycles       (cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctrl ordering: {PCWrite, IF_ID_Write, ID_EX_Bubble, IF_Flush}
  localparam logic [3:0] RUN   = 4'b1100;
  localparam logic [3:0] STALL = 4'b0010;
  localparam logic [3:0] FLUSH = 4'b1101;

  task automatic step(input logic rst, input logic [1:0] br, input logic tk,
                      input logic [4:0] rs_i, input logic [4:0] rt_i,
                      input logic ewr, input logic emr, input logic [4:0] erd,
                      input logic mmr, input logic [4:0] mrd,
                      input logic [3:0] ctrl, input int unsigned cnt, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst; Branch = br; BranchTaken = tk; Rs = rs_i; Rt = rt_i;
    ex_rw = ewr; ex_mr = emr; ex_rd = erd; mem_mr = mmr; mem_rd = mrd;
    e.ctrl = ctrl; e.cnt = cnt; e.name = nm;
    exp_q.push_back(e);
  endtask

  // Monitor: one expected entry per cycle, checked mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [3:0] act, act4, exp4;
      e    = exp_q.pop_front();
      act  = {pcw, ifidw, bub, flush};
      act4 = {pcw4, ifidw4, bub4, flush4};
      exp4 = (e.cnt > 15) ? 4'hF : 4'(e.cnt);
      checks++;
      if (act !== e.ctrl) begin
        failures++;
        $display("FAIL %s ctrl got=%b exp=%b", e.name, act, e.ctrl);
      end
      checks++;
      if (cnt32 !== 32'(e.cnt)) begin
        failures++;
        $display("FAIL %s StallCycles got=%0d exp=%0d", e.name, cnt32, e.cnt);
      end
      checks++;
      if (act4 !== e.ctrl) begin
        failures++;
        $display("FAIL %s ctrl4 got=%b exp=%b", e.name, act4, e.ctrl);
      end
      checks++;
      if (cnt4 !== exp4) begin
        failures++;
        $display("FAIL %s StallCycles4 got=%0d exp=%0d", e.name, cnt4, exp4);
      end
    end
  end

  initial begin
    rst_n = 1'b0; Branch = 2'b00; BranchTaken = 1'b0; Rs = 5'd0; Rt = 5'd0;
    ex_rw = 1'b0; ex_mr = 1'b0; ex_rd = 5'd0; mem_mr = 1'b0; mem_rd = 5'd0;

    //    rst br    tk rs  rt  ewr emr erd mmr mrd ctrl   cnt name
    step(0, 2'b00, 0, 0,  0,  0,  0,  0,  0,  0,  STALL, 0, "reset_hold");
    step(1, 2'b00, 0, 0,  0,  0,  0,  0,  0,  0,  RUN,   0, "idle_run");
    step(1, 2'b01, 0, 1,  2,  1,  1,  1,  0,  0,  STALL, 0, "lw_beq_n");
    step(1, 2'b01, 0, 1,  2,  0,  0,  0,  0,  0,  STALL, 1, "lw_beq_n1");
    step(1, 2'b01, 1, 1,  2,  0,  0,  0,  0,  0,  FLUSH, 2, "lw_beq_n2");
    step(1, 2'b10, 0, 3,  1,  1,  0,  1,  0,  0,  STALL, 2, "alu_bne");
    step(1, 2'b10, 0, 3,  1,  0,  0,  0,  0,  1,  RUN,   3, "alu_bne_next");
    step(1, 2'b00, 0, 5,  4,  1,  1,  4,  0,  0,  STALL, 3, "load_use");
    step(1, 2'b00, 0, 5,  4,  0,  0,  0,  0,  0,  RUN,   4, "load_use_next");
    step(1, 2'b00, 0, 5,  0,  1,  1,  0,  0,  0,  RUN,   4, "dest_zero");
    step(1, 2'b01, 1, 7,  7,  1,  0,  7,  0,  0,  STALL, 4, "taken_hazard");
    step(1, 2'b01, 0, 8,  9,  0,  0,  0,  1,  8,  STALL, 5, "mem_load_br");
    step(1, 2'b01, 0, 8,  9,  0,  0,  0,  0,  8,  RUN,   6, "mem_alu_br");
    step(1, 2'b01, 0, 9,  3,  1,  1,  9,  0,  0,  STALL, 6, "lw_to_wait");
    step(0, 2'b01, 1, 9,  3,  0,  0,  0,  0,  0,  STALL, 0, "reset_in_wait");
    step(1, 2'b00, 0, 0,  0,  0,  0,  0,  0,  0,  RUN,   0, "post_reset");
    step(1, 2'b01, 0, 2,  3,  1,  0,  1,  0,  0,  RUN,   0, "no_match");
    for (int i = 0; i < 20; i++) begin
      step(1, 2'b00, 0, 0, 4, 1, 1, 4, 0, 0, STALL, i, "sat_stall");
    end
    step(1, 2'b00, 0, 0,  0,  0,  0,  0,  0,  0,  RUN,  20, "sat_hold");

    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain queue_left got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
